bellek_modeli: RTL and testbench
================================

// Module: bellek_modeli
// PURPOSE
//  Parametrised memory model that serves both cekirdek bus ports: the l1b instruction fetch port and the bib data port.
//  Wait states are configurable independently per port, and each port is controlled by its own FSM.
//  Adds byte-masked writes, a preload port, out-of-range detection and access counters.
//  Sits in the core test environment between cekirdek and the bench; the RTL is fully synthesizable.
// PARAMETERS
//  DERINLIK       4096          memory depth in 32-bit words (power of two, >=16)
//  TABAN_ADRES    32'h4000_0000 byte address of word 0
//  BUYRUK_GECIKME 1             l1b wait cycles per fetch (>=1)
//  VERI_GECIKME   2             bib wait cycles per access (>=1)
//  HATA_DEGERI    32'hDEAD_BEEF read data returned for out-of-range addresses
// PORTS
//  clk_i             in   1   clock, rising edge
//  rst_i             in   1   asynchronous reset, active-high
//  l1b_adres_i       in   32  fetch byte address from core
//  l1b_deger_o       out  32  fetched instruction word
//  l1b_bekle_o       out  1   1 = fetch not yet valid, core holds address
//  bib_sec_i         in   1   data request valid
//  bib_yaz_gecerli_i in   1   1 = write, 0 = read
//  bib_adr_i         in   32  data byte address
//  bib_veri_i        in   32  write data
//  bib_veri_maske_i  in   4   byte write enables, bit n -> bits 8n+7:8n
//  bib_veri_o        out  32  read data
//  bib_durdur_o      out  1   1 = request in progress, core holds request stable
//  yukle_gecerli_i   in   1   preload full-word write strobe
//  yukle_adr_i       in   32  preload byte address
//  yukle_veri_i      in   32  preload data
//  hata_o            out  1   sticky: an out-of-range access occurred
//  okuma_sayaci_o    out  32  completed bib reads (wraps)
//  yazma_sayaci_o    out  32  completed bib writes (wraps)
// BEHAVIOUR
//  Reset:
//   - all registered outputs, counters and hata_o = 0; both FSMs = BOSTA.
//   - the fetch-valid flag is cleared; memory contents are NOT reset.
//  Addressing: word index = (adr - TABAN_ADRES) >> 2. Bits 1:0 are ignored.
//   Out of range = adr < TABAN_ADRES or adr >= TABAN_ADRES + 4*DERINLIK.
//  l1b FSM, states BOSTA -> BEKLE -> HAZIR:
//   - l1b_bekle_o is combinational: = !(state==HAZIR && l1b_adres_i==son_adres).
//   - New address A first presented in cycle t: bekle_o=1 in cycles t..t+BUYRUK_GECIKME-1.
//   - In cycle t+BUYRUK_GECIKME: l1b_deger_o=mem[A] (registered) and bekle_o=0.
//   - Address change while in BEKLE: abort, counter reloads, latency restarts from the new address.
//   - Address held after HAZIR: stays valid, no re-fetch.
//  bib FSM, states BOSTA -> MESGUL -> TAMAM -> BOSTA:
//   - bib_durdur_o is combinational: = bib_sec_i && state!=TAMAM.
//   - sec_i rising in cycle t: durdur_o=1 for VERI_GECIKME cycles.
//   - In cycle t+VERI_GECIKME: state=TAMAM and durdur_o=0.
//   - Read: bib_veri_o=mem[idx], registered, valid in the TAMAM cycle; holds until the next read completes.
//   - Write: only masked bytes are updated, at the edge entering TAMAM.
//   - TAMAM lasts exactly 1 cycle. sec_i still high in the following cycle = new request.
//   - sec_i dropped in MESGUL: request is abandoned, no write, no count.
//  Counters: increment on entry to TAMAM, read or write accordingly; 32-bit wrap.
//  Simultaneous events:
//   - Same-edge fetch completion and bib write to the same word: fetch returns the old value (read-before-write).
//   - bib write and yukle write to the same word on the same edge: bib wins.
//  Out of range:
//   - reads return HATA_DEGERI; writes and preloads are discarded.
//   - hata_o is set and held until rst_i.
//  Reset mid-operation: both FSMs go to BOSTA immediately; in-flight writes are not performed.
// TESTING
//  1. Reset, preload mem[0]=32'h0000_0013, adres=TABAN -> bekle_o=1 for 1 cycle, then deger=0000_0013, bekle_o=0.
//  2. BUYRUK_GECIKME=3, address changed to TABAN+4 in 2nd wait cycle -> bekle_o stays high 3 more cycles, returns mem[1].
//  3. bib write 32'hAABB_CCDD, mask 4'b0101, to word holding 0 -> read back 0x00BB_00DD; yazma=1, okuma=1.
//  4. bib read of 32'h3FFF_FFFC -> veri_o=DEAD_BEEF, hata_o=1 and sticky; no counter change other than okuma+1.
//  5. bib write and l1b fetch of the same word completing on the same edge -> fetch returns old value; next read returns new.
//  6. rst_i asserted in MESGUL of a write -> no memory change, durdur_o=0 and outputs 0 while reset is held.

Source files
------------

// File: rtl/bellek_modeli.sv
// Dual-port memory model for the cekirdek core: an l1b instruction fetch port and a bib data port.
// Each port has its own wait-state FSM. The model also provides byte-masked writes, preload, range errors and access counters.
module bellek_modeli #(
  parameter int unsigned DERINLIK       = 4096,
  parameter logic [31:0] TABAN_ADRES    = 32'h4000_0000,
  parameter int unsigned BUYRUK_GECIKME = 1,
  parameter int unsigned VERI_GECIKME   = 2,
  parameter logic [31:0] HATA_DEGERI    = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] l1b_adres_i,
  output logic [31:0] l1b_deger_o,
  output logic        l1b_bekle_o,
  input  logic        bib_sec_i,
  input  logic        bib_yaz_gecerli_i,
  input  logic [31:0] bib_adr_i,
  input  logic [31:0] bib_veri_i,
  input  logic [3:0]  bib_veri_maske_i,
  output logic [31:0] bib_veri_o,
  output logic        bib_durdur_o,
  input  logic        yukle_gecerli_i,
  input  logic [31:0] yukle_adr_i,
  input  logic [31:0] yukle_veri_i,
  output logic        hata_o,
  output logic [31:0] okuma_sayaci_o,
  output logic [31:0] yazma_sayaci_o
);
  localparam int unsigned AW = $clog2(DERINLIK);

  typedef enum logic [1:0] {L_BOSTA, L_BEKLE, L_HAZIR} l1b_durum_t;
  typedef enum logic [1:0] {B_BOSTA, B_MESGUL, B_TAMAM} bib_durum_t;

  logic [31:0] mem [DERINLIK];

  function automatic logic aralikta(input logic [31:0] adr);
    logic [31:0] ofs;
    ofs = adr - TABAN_ADRES;
    return (adr >= TABAN_ADRES) && ((ofs >> 2) < DERINLIK);
  endfunction

  function automatic logic [AW-1:0] indeks(input logic [31:0] adr);
    logic [31:0] ofs;
    ofs = adr - TABAN_ADRES;
    return AW'(ofs >> 2);
  endfunction

  l1b_durum_t  l_durum, l_sonraki;
  logic [31:0] l_sayac, l_sayac_d, son_adres;
  logic        l_yukle;
  bib_durum_t  b_durum, b_sonraki;
  logic [31:0] b_sayac, b_sayac_d;
  logic        b_tamamla;

  logic          l_araligi, b_araligi, y_araligi;
  logic [AW-1:0] l_idx, b_idx, y_idx;
  logic          bib_yaz, yukle_yaz;

  assign l_araligi = aralikta(l1b_adres_i);
  assign b_araligi = aralikta(bib_adr_i);
  assign y_araligi = aralikta(yukle_adr_i);
  assign l_idx     = indeks(l1b_adres_i);
  assign b_idx     = indeks(bib_adr_i);
  assign y_idx     = indeks(yukle_adr_i);

  assign l1b_bekle_o  = !(l_durum == L_HAZIR && l1b_adres_i == son_adres);
  assign bib_durdur_o = bib_sec_i && (b_durum != B_TAMAM) && !rst_i;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    l_sonraki = l_durum;
    l_sayac_d = l_sayac;
    l_yukle   = 1'b0;
    // A changed address, or any address while idle, restarts the fetch latency.
    if (l_durum == L_BOSTA || l1b_adres_i != son_adres) begin
      if (BUYRUK_GECIKME == 1) begin
        l_sonraki = L_HAZIR;
        l_yukle   = 1'b1;
      end else begin
        l_sonraki = L_BEKLE;
        l_sayac_d = 32'd1;
      end
    end else if (l_durum == L_BEKLE) begin
      if (l_sayac == BUYRUK_GECIKME - 1) begin
        l_sonraki = L_HAZIR;
        l_yukle   = 1'b1;
      end else begin
        l_sayac_d = l_sayac + 32'd1;
      end
    end
  end

  always_comb begin
    b_sonraki = b_durum;
    b_sayac_d = b_sayac;
    b_tamamla = 1'b0;
    case (b_durum)
      B_BOSTA, B_TAMAM: begin
        if (!bib_sec_i) begin
          b_sonraki = B_BOSTA;
        end else if (VERI_GECIKME == 1) begin
          b_sonraki = B_TAMAM;
          b_tamamla = 1'b1;
        end else begin
          b_sonraki = B_MESGUL;
          b_sayac_d = 32'd1;
        end
      end
      B_MESGUL: begin
        if (!bib_sec_i) begin
          b_sonraki = B_BOSTA;
        end else if (b_sayac == VERI_GECIKME - 1) begin
          b_sonraki = B_TAMAM;
          b_tamamla = 1'b1;
        end else begin
          b_sayac_d = b_sayac + 32'd1;
        end
      end
      default: b_sonraki = B_BOSTA;
    endcase
  end

  // The bib write takes the whole word from a same-edge preload.
  assign bib_yaz   = b_tamamla && bib_yaz_gecerli_i && b_araligi && !rst_i;
  assign yukle_yaz = yukle_gecerli_i && y_araligi && !(bib_yaz && y_idx == b_idx);

  // NOTE: the memory array has no reset; its contents survive rst_i and only the control state is cleared.
  always_ff @(posedge clk_i) begin
    if (bib_yaz) begin
      for (int b = 0; b < 4; b++) begin
        if (bib_veri_maske_i[b]) mem[b_idx][8*b +: 8] <= bib_veri_i[8*b +: 8];
      end
    end
    if (yukle_yaz) mem[y_idx] <= yukle_veri_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      l_durum        <= L_BOSTA;
      l_sayac        <= '0;
      son_adres      <= '0;
      l1b_deger_o    <= '0;
      b_durum        <= B_BOSTA;
      b_sayac        <= '0;
      bib_veri_o     <= '0;
      okuma_sayaci_o <= '0;
      yazma_sayaci_o <= '0;
      hata_o         <= 1'b0;
    end else begin
      l_durum   <= l_sonraki;
      l_sayac   <= l_sayac_d;
      son_adres <= l1b_adres_i;
      b_durum   <= b_sonraki;
      b_sayac   <= b_sayac_d;
      if (l_yukle) l1b_deger_o <= l_araligi ? mem[l_idx] : HATA_DEGERI;
      if (b_tamamla) begin
        if (bib_yaz_gecerli_i) begin
          yazma_sayaci_o <= yazma_sayaci_o + 32'd1;
        end else begin
          okuma_sayaci_o <= okuma_sayaci_o + 32'd1;
          bib_veri_o     <= b_araligi ? mem[b_idx] : HATA_DEGERI;
        end
      end
      if ((l_yukle && !l_araligi) || (b_tamamla && !b_araligi) ||
          (yukle_gecerli_i && !y_araligi)) begin
        hata_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bellek_modeli.sv
// Directed scoreboard bench for bellek_modeli: two instances, one with default wait states and one with a 3-cycle fetch.
// Expected read data is queued as stimulus is driven and popped when the port reports completion.
module tb_bellek_modeli;
  localparam logic [31:0] TABAN = 32'h4000_0000;
  localparam logic [31:0] HATA  = 32'hDEAD_BEEF;
  localparam int          VG    = 2;

  typedef struct {
    string       etiket;
    logic [31:0] deger;
  } beklenti_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] l1b_adres, l1b_deger, l1b_adres3, l1b_deger3;
  logic        l1b_bekle, l1b_bekle3;
  logic        bib_sec, bib_yaz;
  logic [31:0] bib_adr, bib_veri_w, bib_veri_r, bib_veri_r3;
  logic [3:0]  bib_maske;
  logic        bib_durdur, bib_durdur3;
  logic        yukle_gecerli;
  logic [31:0] yukle_adr, yukle_veri;
  logic        hata, hata3;
  logic [31:0] okuma, yazma, okuma3, yazma3;

  beklenti_t   beklenen_q[$];
  int          kontrol_sayisi = 0;
  int          hata_sayisi    = 0;
  logic [31:0] okuma_beklenen = 32'd0;
  logic [31:0] yazma_beklenen = 32'd0;

  logic [31:0] on_adr  [6] = '{TABAN, TABAN + 32'd4, TABAN + 32'd20, TABAN + 32'd24,
                               TABAN + 32'd28, TABAN + 32'h3FFC};
  logic [31:0] on_veri [6] = '{32'h0000_0013, 32'h0000_0093, 32'h0000_0000, 32'h1111_1111,
                               32'h7777_7777, 32'h5A5A_0FF0};

  bellek_modeli dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .l1b_adres_i(l1b_adres), .l1b_deger_o(l1b_deger), .l1b_bekle_o(l1b_bekle),
    .bib_sec_i(bib_sec), .bib_yaz_gecerli_i(bib_yaz), .bib_adr_i(bib_adr),
    .bib_veri_i(bib_veri_w), .bib_veri_maske_i(bib_maske), .bib_veri_o(bib_veri_r),
    .bib_durdur_o(bib_durdur),
    .yukle_gecerli_i(yukle_gecerli), .yukle_adr_i(yukle_adr), .yukle_veri_i(yukle_veri),
    .hata_o(hata), .okuma_sayaci_o(okuma), .yazma_sayaci_o(yazma)
  );

  bellek_modeli #(.BUYRUK_GECIKME(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .l1b_adres_i(l1b_adres3), .l1b_deger_o(l1b_deger3), .l1b_bekle_o(l1b_bekle3),
    .bib_sec_i(1'b0), .bib_yaz_gecerli_i(1'b0), .bib_adr_i(TABAN),
    .bib_veri_i(32'd0), .bib_veri_maske_i(4'd0), .bib_veri_o(bib_veri_r3),
    .bib_durdur_o(bib_durdur3),
    .yukle_gecerli_i(yukle_gecerli), .yukle_adr_i(yukle_adr), .yukle_veri_i(yukle_veri),
    .hata_o(hata3), .okuma_sayaci_o(okuma3), .yazma_sayaci_o(yazma3)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    assert (gozlenen === beklenen) else begin
      hata_sayisi++;
      $error("FAIL %s: observed %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic pop_check(input logic [31:0] gozlenen);
    beklenti_t b;
    kontrol_sayisi++;
    assert (beklenen_q.size() != 0) else begin
      hata_sayisi++;
      $error("FAIL scoreboard_empty: observed %h expected none", gozlenen);
    end
    if (beklenen_q.size() != 0) begin
      b = beklenen_q.pop_front();
      check(b.etiket, gozlenen, b.deger);
    end
  endtask

  task automatic sonraki();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sayac_kontrol(input string etiket);
    check({etiket, "_okuma"}, okuma, okuma_beklenen);
    check({etiket, "_yazma"}, yazma, yazma_beklenen);
  endtask

  // One complete bib transaction; the cycle after completion drops sec so the FSM returns to idle.
  task automatic bib_islem(input string etiket, input logic yaz, input logic [31:0] adr,
                           input logic [31:0] veri, input logic [3:0] maske, input logic [31:0] beklenen);
    bib_sec = 1'b1; bib_yaz = yaz; bib_adr = adr; bib_veri_w = veri; bib_maske = maske;
    if (!yaz) beklenen_q.push_back('{etiket, beklenen});
    for (int k = 0; k < VG; k++) begin
      @(negedge clk_i);
      check({etiket, "_durdur"}, 32'(bib_durdur), 32'd1);
      sonraki();
    end
    @(negedge clk_i);
    check({etiket, "_tamam"}, 32'(bib_durdur), 32'd0);
    if (yaz) yazma_beklenen++;
    else begin
      okuma_beklenen++;
      pop_check(bib_veri_r);
    end
    sayac_kontrol(etiket);
    sonraki();
    bib_sec = 1'b0;
    sonraki();
  endtask

  initial begin
    rst_i = 1'b1; bib_sec = 1'b0; bib_yaz = 1'b0; bib_adr = TABAN; bib_veri_w = '0; bib_maske = '0;
    yukle_gecerli = 1'b0; yukle_adr = '0; yukle_veri = '0;
    l1b_adres = TABAN + 32'h100; l1b_adres3 = TABAN + 32'h100;
    sonraki();

    // Preload while reset is held; memory is not cleared by reset.
    for (int i = 0; i < 6; i++) begin
      yukle_gecerli = 1'b1; yukle_adr = on_adr[i]; yukle_veri = on_veri[i];
      sonraki();
    end
    yukle_gecerli = 1'b0;

    @(negedge clk_i);
    check("rst_deger", l1b_deger, 32'd0);
    check("rst_bib_veri", bib_veri_r, 32'd0);
    check("rst_durdur", 32'(bib_durdur), 32'd0);
    check("rst_hata", 32'(hata), 32'd0);
    sayac_kontrol("rst");
    sonraki();

    // Fetch with one wait cycle.
    rst_i = 1'b0; l1b_adres = TABAN; l1b_adres3 = TABAN + 32'd8;
    beklenen_q.push_back('{"fetch_w0", 32'h0000_0013});
    @(negedge clk_i);
    check("fetch_bekle_t", 32'(l1b_bekle), 32'd1);
    sonraki();
    @(negedge clk_i);
    check("fetch_bekle_t1", 32'(l1b_bekle), 32'd0);
    pop_check(l1b_deger);
    sonraki();
    @(negedge clk_i);
    check("fetch_hold_bekle", 32'(l1b_bekle), 32'd0);
    check("fetch_hold_deger", l1b_deger, 32'h0000_0013);
    sonraki();

    // Three-cycle fetch, address changed in the second wait cycle.
    l1b_adres3 = TABAN + 32'd12;
    @(negedge clk_i);
    check("abort_c0", 32'(l1b_bekle3), 32'd1);
    sonraki();
    l1b_adres3 = TABAN + 32'd4;
    beklenen_q.push_back('{"abort_w1", 32'h0000_0093});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      check("abort_wait", 32'(l1b_bekle3), 32'd1);
      sonraki();
    end
    @(negedge clk_i);
    check("abort_done", 32'(l1b_bekle3), 32'd0);
    pop_check(l1b_deger3);
    sonraki();

    // Byte-masked write then read back.
    bib_islem("mask_wr", 1'b1, TABAN + 32'd20, 32'hAABB_CCDD, 4'b0101, 32'd0);
    bib_islem("mask_rd", 1'b0, TABAN + 32'd20, 32'd0, 4'd0, 32'h00BB_00DD);

    // Last in-range word, then both out-of-range sides.
    bib_islem("last_word", 1'b0, TABAN + 32'h3FFC, 32'd0, 4'd0, 32'h5A5A_0FF0);
    check("last_word_hata", 32'(hata), 32'd0);
    bib_islem("below_base", 1'b0, 32'h3FFF_FFFC, 32'd0, 4'd0, HATA);
    check("below_hata", 32'(hata), 32'd1);
    bib_islem("above_top", 1'b0, TABAN + 32'h4000, 32'd0, 4'd0, HATA);
    check("hata_sticky", 32'(hata), 32'd1);

    // Same-edge bib write, fetch completion and preload on word 6.
    bib_sec = 1'b1; bib_yaz = 1'b1; bib_adr = TABAN + 32'd24; bib_veri_w = 32'hCAFE_F00D; bib_maske = 4'hF;
    @(negedge clk_i);
    check("rbw_durdur0", 32'(bib_durdur), 32'd1);
    sonraki();
    l1b_adres = TABAN + 32'd24;
    yukle_gecerli = 1'b1; yukle_adr = TABAN + 32'd24; yukle_veri = 32'h2222_2222;
    beklenen_q.push_back('{"rbw_fetch_old", 32'h1111_1111});
    @(negedge clk_i);
    check("rbw_bekle", 32'(l1b_bekle), 32'd1);
    check("rbw_durdur1", 32'(bib_durdur), 32'd1);
    sonraki();
    yukle_gecerli = 1'b0;
    yazma_beklenen++;
    @(negedge clk_i);
    check("rbw_tamam", 32'(bib_durdur), 32'd0);
    check("rbw_bekle_done", 32'(l1b_bekle), 32'd0);
    pop_check(l1b_deger);
    sayac_kontrol("rbw");
    sonraki();
    bib_sec = 1'b0;
    sonraki();
    bib_islem("rbw_read_new", 1'b0, TABAN + 32'd24, 32'd0, 4'd0, 32'hCAFE_F00D);

    // Reset asserted while a write is waiting.
    bib_sec = 1'b1; bib_yaz = 1'b1; bib_adr = TABAN + 32'd28; bib_veri_w = 32'd0; bib_maske = 4'hF;
    @(negedge clk_i);
    check("rstmid_durdur0", 32'(bib_durdur), 32'd1);
    sonraki();
    rst_i = 1'b1;
    okuma_beklenen = 32'd0; yazma_beklenen = 32'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("rstmid_durdur", 32'(bib_durdur), 32'd0);
      check("rstmid_deger", l1b_deger, 32'd0);
      check("rstmid_bib_veri", bib_veri_r, 32'd0);
      check("rstmid_hata", 32'(hata), 32'd0);
      sayac_kontrol("rstmid");
      sonraki();
    end
    bib_sec = 1'b0; rst_i = 1'b0; l1b_adres = TABAN + 32'd28;
    beklenen_q.push_back('{"rstmid_fetch", 32'h7777_7777});
    @(negedge clk_i);
    check("rstmid_bekle", 32'(l1b_bekle), 32'd1);
    sonraki();
    @(negedge clk_i);
    pop_check(l1b_deger);
    sonraki();
    bib_islem("rstmid_read", 1'b0, TABAN + 32'd28, 32'd0, 4'd0, 32'h7777_7777);

    // The second instance's data port stayed idle throughout.
    check("dut3_okuma", okuma3, 32'd0);
    check("dut3_yazma", yazma3, 32'd0);
    check("dut3_veri", bib_veri_r3, 32'd0);
    check("dut3_durdur", 32'(bib_durdur3), 32'd0);
    check("dut3_hata", 32'(hata3), 32'd0);
    check("queue_drained", 32'(beklenen_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
